load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
Sits between the datapath (ALU result and rt register value) and the data memory. The data memory is byte-addressed, little-endian, reads a word combinationally and writes a full word on posedge.
- Loads: adds byte/halfword/word loads with sign or zero extension.
- Stores: byte and halfword stores are done as a 2-cycle read-modify-write, with a stall output to the core.
- Checks: flags misaligned and out-of-range accesses and suppresses the access.

Parameters:
MEM_BYTES, 256, size of data memory in bytes; an access is in range iff addr + nbytes <= MEM_BYTES

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  memory instruction present this cycle
req_write  input  1  1 = store, 0 = load
req_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as error)
req_signed  input  1  loads only: 1 = sign-extend, 0 = zero-extend
req_addr  input  32  byte address from ALU
req_wdata  input  32  store data, low bits used for sub-word stores
stall  output  1  core must hold PC and pipeline registers this cycle
done  output  1  access completes this cycle
rdata  output  32  extended load result, valid when done && !req_write
err  output  1  pulse: current request rejected (misaligned/range/reserved size)
err_sticky  output  1  set on any err, cleared only by reset
mem_A  output  32  address to data memory, always word-aligned (addr & ~3)
mem_WD  output  32  write data to data memory
mem_MemWrite  output  1  write enable to data memory
mem_RD  input  32  combinational read data from data memory

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; merge_q = 0; addr_q = 0; err_sticky = 0.
  - Outputs while in reset: stall = 0, done = 0, err = 0, mem_MemWrite = 0, rdata = 0.
- Request decode (combinational, IDLE only):
  - nbytes = 1/2/4 from req_size.
  - Misaligned: halfword with addr[0] = 1, or word with addr[1:0] != 0.
  - Bad = misaligned OR out of range OR size = 11.
  - Bad request: err = 1, done = 1, stall = 0, mem_MemWrite = 0, rdata = 0; err_sticky sets on the clock edge.
- Lane select: byte lane = addr[1:0]; halfword lane = addr[1].
- Load, IDLE:
  - mem_A = addr & ~3.
  - rdata = selected lane of mem_RD, sign- or zero-extended to 32 bits.
  - done = 1, stall = 0; zero latency, no state change.
- Word store, IDLE:
  - mem_A = addr, mem_WD = req_wdata, mem_MemWrite = 1.
  - done = 1, stall = 0; the memory commits on this posedge.
- Sub-word store, IDLE (cycle 0):
  - mem_A = addr & ~3; mem_MemWrite = 0; stall = 1; done = 0.
  - On posedge: merge_q = mem_RD with the target lane(s) replaced by req_wdata[7:0] or [15:0]; addr_q = addr & ~3; state -> WRITE.
- WRITE state (cycle 1):
  - mem_A = addr_q, mem_WD = merge_q, mem_MemWrite = 1.
  - stall = 0, done = 1.
  - Request inputs are ignored in this state; the core holds them but they are not sampled.
  - Next posedge: state -> IDLE.
- Store latency: 1 cycle for a word store; 2 cycles for a sub-word store, with exactly one stall cycle.
- req_valid = 0 in IDLE: all outputs idle (mem_MemWrite = 0, done = 0, stall = 0). mem_A follows req_addr & ~3 so reads stay defined.
- Reset asserted during WRITE: mem_MemWrite drops immediately; no write reaches memory; state = IDLE.
- States: IDLE, WRITE only. Encoding is free; an illegal state recovers to IDLE on the next clock.
- Width rule: the range check uses 33-bit addr + nbytes so wrap-around near 0xFFFFFFFF is caught as out of range.

Test Plan:
- Memory preloaded with byte[i] = i for i >= 16. Load word at 0x10 -> rdata = 0x13121110, done = 1, stall = 0 in the same cycle.
- Load byte signed at 0x80 -> rdata = 0xFFFFFF80. Same address unsigned -> 0x00000080. Load halfword signed at 0xFE -> 0xFFFFFFFE.
- Store byte 0x000000AB at 0x12:
  - stall = 1 for one cycle, then mem_MemWrite = 1 with mem_A = 0x10, mem_WD = 0x13AB1110.
  - A subsequent word load at 0x10 returns 0x13AB1110.
- Store halfword 0xBEEF at 0x16 -> word at 0x14 becomes 0xBEEF1514. Store word 0xDEADBEEF at 0x20 -> written in 1 cycle with no stall.
- Error cases, each must give err = 1, no write, err_sticky = 1 afterwards:
  - halfword store at 0x13;
  - word load at 0x100 (out of range);
  - word load at 0xFFFFFFFC (range check wraps);
  - size = 11.
- Sub-word store at 0x21: pull rst_n low while in WRITE -> mem_MemWrite = 0 immediately, byte 0x21 unchanged, state IDLE, err_sticky = 0.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Core-side request/response bundle of the load/store unit.
// The core drives requests (master); the LSU answers (slave).
interface load_store_unit_if;
    logic        req_valid;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        done;
    logic [31:0] rdata;
    logic        err;
    logic        err_sticky;

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  stall, done, rdata, err, err_sticky
    );

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output stall, done, rdata, err, err_sticky
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: extended sub-word loads, read-modify-write sub-word stores,
// and misalignment/range rejection in front of a word-wide data memory.
module load_store_unit #(
    parameter int unsigned MEM_BYTES = 256
) (
    input  logic               clk,
    input  logic               rst_n,
    load_store_unit_if.slave   bus,
    output logic [31:0]        mem_A,
    output logic [31:0]        mem_WD,
    output logic               mem_MemWrite,
    input  logic [31:0]        mem_RD
);

    typedef enum logic [1:0] {
        IDLE  = 2'b01,
        WRITE = 2'b10
    } state_t;

    state_t      state_r;
    state_t      next_state_s;
    logic [31:0] merge_r;
    logic [31:0] merge_s;
    logic [31:0] addr_r;
    logic [31:0] addr_s;
    logic        err_sticky_r;

    logic [2:0]  nbytes_s;
    logic [32:0] end_addr_s;
    logic        misaligned_s;
    logic        range_bad_s;
    logic        bad_s;
    logic [31:0] aligned_s;

    logic        stall_s;
    logic        done_s;
    logic        err_s;
    logic [31:0] rdata_s;
    logic [31:0] mem_a_s;
    logic [31:0] mem_wd_s;
    logic        mem_we_s;

    function automatic logic [31:0] merge_lanes(
        input logic [31:0] word,
        input logic [1:0]  lane,
        input logic        half,
        input logic [15:0] wdata
    );
        logic [31:0] res;
        res = word;
        if (half) begin
            if (lane[1]) begin
                res[31:16] = wdata;
            end else begin
                res[15:0] = wdata;
            end
        end else begin
            case (lane)
                2'd0:    res[7:0]   = wdata[7:0];
                2'd1:    res[15:8]  = wdata[7:0];
                2'd2:    res[23:16] = wdata[7:0];
                default: res[31:24] = wdata[7:0];
            endcase
        end
        return res;
    endfunction

    function automatic logic [31:0] extract_load(
        input logic [31:0] word,
        input logic [1:0]  lane,
        input logic [1:0]  size,
        input logic        sgn
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   res = sgn ? {{24{b[7]}}, b} : {24'h000000, b};
            2'b01:   res = sgn ? {{16{h[15]}}, h} : {16'h0000, h};
            2'b10:   res = word;
            default: res = 32'h0000_0000;
        endcase
        return res;
    endfunction

    // Request decode: size, alignment and 33-bit range check (catches wrap-around).
    always_comb begin
        case (bus.req_size)
            2'b00:   nbytes_s = 3'd1;
            2'b01:   nbytes_s = 3'd2;
            default: nbytes_s = 3'd4;
        endcase
        aligned_s    = {bus.req_addr[31:2], 2'b00};
        misaligned_s = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                       ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));
        end_addr_s   = {1'b0, bus.req_addr} + {30'h0, nbytes_s};
        range_bad_s  = end_addr_s > 33'(MEM_BYTES);
        bad_s        = misaligned_s || range_bad_s || (bus.req_size == 2'b11);
    end

    // Next-state and output logic of the IDLE/WRITE controller.
    always_comb begin
        next_state_s = state_r;
        merge_s      = merge_r;
        addr_s       = addr_r;
        stall_s      = 1'b0;
        done_s       = 1'b0;
        err_s        = 1'b0;
        rdata_s      = 32'h0000_0000;
        mem_a_s      = aligned_s;
        mem_wd_s     = 32'h0000_0000;
        mem_we_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (!bus.req_valid) begin
                    next_state_s = IDLE;
                end else if (bad_s) begin
                    err_s  = 1'b1;
                    done_s = 1'b1;
                end else if (!bus.req_write) begin
                    rdata_s = extract_load(mem_RD, bus.req_addr[1:0], bus.req_size, bus.req_signed);
                    done_s  = 1'b1;
                end else if (bus.req_size == 2'b10) begin
                    mem_a_s  = bus.req_addr;
                    mem_wd_s = bus.req_wdata;
                    mem_we_s = 1'b1;
                    done_s   = 1'b1;
                end else begin
                    // Sub-word store: capture the merged word now, write it next cycle.
                    stall_s      = 1'b1;
                    merge_s      = merge_lanes(mem_RD, bus.req_addr[1:0], bus.req_size[0],
                                               bus.req_wdata[15:0]);
                    addr_s       = aligned_s;
                    next_state_s = WRITE;
                end
            end
            WRITE: begin
                mem_a_s      = addr_r;
                mem_wd_s     = merge_r;
                mem_we_s     = 1'b1;
                done_s       = 1'b1;
                next_state_s = IDLE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Controller state, merge buffer and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            merge_r      <= 32'h0000_0000;
            addr_r       <= 32'h0000_0000;
            err_sticky_r <= 1'b0;
        end else begin
            state_r      <= next_state_s;
            merge_r      <= merge_s;
            addr_r       <= addr_s;
            err_sticky_r <= err_sticky_r | err_s;
        end
    end

    // Reset forces every strobe low at once, so an in-flight write never lands.
    assign bus.stall      = rst_n & stall_s;
    assign bus.done       = rst_n & done_s;
    assign bus.err        = rst_n & err_s;
    assign bus.rdata      = rst_n ? rdata_s : 32'h0000_0000;
    assign bus.err_sticky = err_sticky_r;
    assign mem_A          = mem_a_s;
    assign mem_WD         = mem_wd_s;
    assign mem_MemWrite   = rst_n & mem_we_s;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: byte-level reference model, directed
// cases from the plan, then randomized traffic.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        preload;
    logic [31:0] mem_A;
    logic [31:0] mem_WD;
    logic        mem_MemWrite;
    logic [31:0] mem_RD;

    logic [7:0]  mem     [256];
    logic [7:0]  ref_mem [256];
    logic        sticky_m;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        err;
        logic        ld;
        logic        wr;
        logic [31:0] rdata;
        logic [31:0] a;
        logic [31:0] wd;
    } exp_t;
    exp_t sb_q[$];

    load_store_unit_if ifc();

    load_store_unit #(.MEM_BYTES(256)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (ifc),
        .mem_A        (mem_A),
        .mem_WD       (mem_WD),
        .mem_MemWrite (mem_MemWrite),
        .mem_RD       (mem_RD)
    );

    always #5 clk = ~clk;

    // Data memory: little-endian, combinational word read, full-word write on posedge.
    always_comb begin
        mem_RD = {mem[{mem_A[7:2], 2'd3}], mem[{mem_A[7:2], 2'd2}],
                  mem[{mem_A[7:2], 2'd1}], mem[{mem_A[7:2], 2'd0}]};
    end

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem[i] <= (i >= 16) ? 8'(i) : 8'h00;
        end else if (mem_MemWrite) begin
            mem[{mem_A[7:2], 2'd0}] <= mem_WD[7:0];
            mem[{mem_A[7:2], 2'd1}] <= mem_WD[15:8];
            mem[{mem_A[7:2], 2'd2}] <= mem_WD[23:16];
            mem[{mem_A[7:2], 2'd3}] <= mem_WD[31:24];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every completed access is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ifc.done) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_done", 32'(ifc.done), 32'h0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("err", 32'(ifc.err), 32'(e.err));
                    chk("mem_write", 32'(mem_MemWrite), 32'(e.wr));
                    if (e.wr) begin
                        chk("mem_A", mem_A, e.a);
                        chk("mem_WD", mem_WD, e.wd);
                    end
                    if (e.ld || e.err) chk("rdata", ifc.rdata, e.rdata);
                end
            end else if (mem_MemWrite) begin
                chk("write_without_done", 32'(mem_MemWrite), 32'h0);
            end
        end
    end

    // Reference model + driver: computes the expected outcome from byte-level
    // rules, queues it, applies the request and waits for completion.
    task automatic do_req(input logic wr, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rd, output logic [31:0] wd);
        exp_t            e;
        int              nb;
        longint unsigned val;
        logic            bad;
        int              stalls;
        int              exp_stalls;
        logic            finished;
        nb  = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        bad = (size == 2'b11) || ((addr % nb) != 0) ||
              ((longint'(addr) + longint'(nb)) > 64'd256);
        e.err = bad; e.ld = 1'b0; e.wr = 1'b0;
        e.rdata = 32'h0; e.a = 32'h0; e.wd = 32'h0;
        exp_stalls = 0;
        if (!bad && !wr) begin
            val = 0;
            for (int i = 0; i < nb; i++) val |= longint'(ref_mem[addr + i]) << (8 * i);
            if (sgn && nb < 4 && ((val >> (8 * nb - 1)) & 1) == 1)
                val |= ~64'h0 << (8 * nb);
            e.ld = 1'b1;
            e.rdata = val[31:0];
        end else if (!bad) begin
            for (int i = 0; i < nb; i++) ref_mem[addr + i] = 8'(wdata >> (8 * i));
            e.wr = 1'b1;
            e.a  = addr & ~32'h3;
            for (int i = 0; i < 4; i++) e.wd[8*i +: 8] = ref_mem[e.a + i];
            exp_stalls = (nb < 4) ? 1 : 0;
        end
        @(posedge clk);
        #1;
        chk("err_sticky", 32'(ifc.err_sticky), 32'(sticky_m));
        if (bad) sticky_m = 1'b1;
        sb_q.push_back(e);
        ifc.req_valid = 1'b1; ifc.req_write = wr; ifc.req_size = size;
        ifc.req_signed = sgn; ifc.req_addr = addr; ifc.req_wdata = wdata;
        stalls = 0; finished = 1'b0; rd = 32'h0; wd = 32'h0;
        for (int c = 0; c < 4 && !finished; c++) begin
            @(negedge clk);
            if (ifc.done) begin
                finished = 1'b1;
                rd = ifc.rdata;
                wd = mem_WD;
            end else if (ifc.stall) begin
                stalls++;
            end
        end
        chk("completed", 32'(finished), 32'h1);
        chk("stall_cycles", 32'(stalls), 32'(exp_stalls));
    endtask

    logic [31:0] rd, wd;

    initial begin
        rst_n = 1'b0; preload = 1'b1; sticky_m = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = (i >= 16) ? 8'(i) : 8'h00;
        ifc.req_valid = 1'b1; ifc.req_write = 1'b0; ifc.req_size = 2'b10;
        ifc.req_signed = 1'b0; ifc.req_addr = 32'h10; ifc.req_wdata = 32'h0;
        #3;
        chk("rst_stall", 32'(ifc.stall), 32'h0);
        chk("rst_done", 32'(ifc.done), 32'h0);
        chk("rst_err", 32'(ifc.err), 32'h0);
        chk("rst_memwrite", 32'(mem_MemWrite), 32'h0);
        chk("rst_rdata", ifc.rdata, 32'h0);
        chk("rst_sticky", 32'(ifc.err_sticky), 32'h0);
        repeat (2) @(posedge clk);
        #1; preload = 1'b0; ifc.req_valid = 1'b0;
        @(negedge clk); rst_n = 1'b1;

        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, wd);
        chk("lw_0x10", rd, 32'h13121110);
        do_req(1'b0, 2'b00, 1'b1, 32'h80, 32'h0, rd, wd);
        chk("lb_0x80", rd, 32'hFFFFFF80);
        do_req(1'b0, 2'b00, 1'b0, 32'h80, 32'h0, rd, wd);
        chk("lbu_0x80", rd, 32'h00000080);
        do_req(1'b0, 2'b01, 1'b1, 32'hFE, 32'h0, rd, wd);
        chk("lh_0xfe", rd, 32'hFFFFFFFE);
        do_req(1'b1, 2'b00, 1'b0, 32'h12, 32'h000000AB, rd, wd);
        chk("sb_wd", wd, 32'h13AB1110);
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, wd);
        chk("lw_after_sb", rd, 32'h13AB1110);
        do_req(1'b1, 2'b01, 1'b0, 32'h16, 32'h0000BEEF, rd, wd);
        do_req(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, rd, wd);
        chk("lw_after_sh", rd, 32'hBEEF1514);
        do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'hDEADBEEF, rd, wd);
        do_req(1'b1, 2'b01, 1'b0, 32'h13, 32'h1234, rd, wd);
        do_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, rd, wd);
        do_req(1'b0, 2'b10, 1'b0, 32'hFFFFFFFC, 32'h0, rd, wd);
        do_req(1'b0, 2'b11, 1'b0, 32'h40, 32'h0, rd, wd);

        // Reset while the sub-word write is pending must drop the write.
        @(posedge clk);
        #1;
        chk("sticky_before_rst", 32'(ifc.err_sticky), 32'h1);
        ifc.req_valid = 1'b1; ifc.req_write = 1'b1; ifc.req_size = 2'b00;
        ifc.req_addr = 32'h21; ifc.req_wdata = 32'h55;
        @(negedge clk);
        chk("rmw_stall", 32'(ifc.stall), 32'h1);
        @(posedge clk);
        #1;
        chk("write_pending", 32'(mem_MemWrite), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_drop_write", 32'(mem_MemWrite), 32'h0);
        chk("rst_drop_done", 32'(ifc.done), 32'h0);
        chk("rst_sticky_clr", 32'(ifc.err_sticky), 32'h0);
        @(posedge clk);
        #1 ifc.req_valid = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
        sticky_m = 1'b0;
        chk("byte_0x21_kept", 32'(mem[33]), 32'h000000BE);
        do_req(1'b0, 2'b00, 1'b0, 32'h21, 32'h0, rd, wd);
        chk("lbu_0x21", rd, 32'h000000BE);

        for (int n = 0; n < 300; n++) begin
            logic        w;
            logic [1:0]  sz;
            logic [31:0] a;
            int          r;
            w  = 1'($urandom % 2);
            r  = int'($urandom % 8);
            sz = (r < 7) ? 2'(r % 3) : 2'b11;
            a  = (($urandom % 16) == 0) ? (32'hFFFFFFF0 + ($urandom % 16)) : $urandom_range(0, 263);
            if (($urandom % 4) != 0) a = (sz == 2'b01) ? (a & ~32'h1) : (sz == 2'b10) ? (a & ~32'h3) : a;
            do_req(w, sz, 1'($urandom % 2), a, $urandom, rd, wd);
        end

        @(posedge clk);
        #1 ifc.req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("queue_drained", 32'(sb_q.size()), 32'h0);
        for (int i = 0; i < 256; i++) chk("mem_image", 32'(mem[i]), 32'(ref_mem[i]));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
